// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store unit bridging the execute stage to a req/ack memory bus
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_load,
    input  logic        req_store,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [2:0]  funct3,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        access_err,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [7:0]  wait_cnt;
    logic [1:0]  off;
    logic [2:0]  f3;
    logic        req;
    logic        f3_ok;
    logic        align_ok;
    logic        legal;
    logic [3:0]  sel;
    logic [31:0] wdata;
    logic [15:0] lane;
    logic [31:0] ext;

    // Decode the incoming request: legality, lane mask and replicated store data
    always_comb begin
        req = req_load | req_store;
        f3_ok = req_load ? (funct3[1:0] != 2'b11 && funct3 != 3'b110)
                         : (!funct3[2] && funct3[1:0] != 2'b11);
        align_ok = funct3[1] ? (addr[1:0] == 2'b00) : (!funct3[0] || !addr[0]);
        legal = f3_ok && align_ok;
        sel = funct3[1] ? 4'b1111 : funct3[0] ? 4'b0011 << addr[1:0] : 4'b0001 << addr[1:0];
        wdata = funct3[1] ? store_data : funct3[0] ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
    end

    // Pick the addressed byte/half out of the read word and extend it
    always_comb begin
        lane = 16'(bus_rdata >> {off, 3'b000});
        ext = f3[1] ? bus_rdata
            : f3[0] ? {{16{~f3[2] & lane[15]}}, lane}
                    : {{24{~f3[2] & lane[7]}}, lane[7:0]};
    end

    // Upstream freeze: held while a legal request is taken and during the bus access
    assign stall = !rst && ((state == IDLE && req && legal) || state == ACCESS);

    // Access FSM with registered bus and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            off         <= '0;
            f3          <= '0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_sel     <= '0;
            load_data   <= '0;
            load_valid  <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            load_valid  <= 1'b0;
            access_err  <= 1'b0;
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req && legal) begin
                        state     <= ACCESS;
                        wait_cnt  <= '0;
                        off       <= addr[1:0];
                        f3        <= funct3;
                        bus_req   <= 1'b1;
                        bus_we    <= !req_load;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_sel   <= sel;
                        bus_wdata <= wdata;
                    end else if (req) begin
                        access_err <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (bus_ack) begin
                        state   <= DONE;
                        bus_req <= 1'b0;
                        if (!bus_we) begin
                            load_data  <= ext;
                            load_valid <= 1'b1;
                        end
                    end else if (wait_cnt == 8'(TIMEOUT_CYCLES - 1)) begin
                        state       <= IDLE;
                        bus_req     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: timeline-model bench for the load/store unit
module tb_mem_access_unit;
    localparam int TO = 4;
    localparam int N = 1024;

    logic        clk = 0;
    logic        rst = 1;
    logic        req_load = 0;
    logic        req_store = 0;
    logic [31:0] addr = 0;
    logic [31:0] store_data = 0;
    logic [2:0]  funct3 = 0;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_ack = 0;
    logic [31:0] bus_rdata = 0;
    logic [31:0] load_data;
    logic        load_valid;
    logic        stall;
    logic        access_err;
    logic        timeout_err;

    mem_access_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_load(req_load), .req_store(req_store),
        .addr(addr), .store_data(store_data), .funct3(funct3),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_sel(bus_sel), .bus_ack(bus_ack),
        .bus_rdata(bus_rdata), .load_data(load_data), .load_valid(load_valid),
        .stall(stall), .access_err(access_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // expected per-cycle timeline, filled by the stimulus from the latency rules
    bit        exp_req [N];
    bit        exp_stall [N];
    bit        exp_lv [N];
    bit        exp_err [N];
    bit        exp_to [N];
    bit        exp_we [N];
    bit [31:0] exp_addr [N];
    bit [3:0]  exp_sel [N];
    bit [31:0] exp_wd [N];
    bit [31:0] exp_ld [N];

    int n_tests = 0;
    int n_fail = 0;
    bit checks_on = 0;
    logic [31:0] snap_wd;
    logic [3:0]  snap_sel;
    logic        snap_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, act, exp);
        end
    endtask

    function automatic int size_m(input logic [2:0] f3);
        return (f3 == 3'd2) ? 4 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 1;
    endfunction

    function automatic bit legal_m(input bit ld, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        ok = ld ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5) : (f3 == 0 || f3 == 1 || f3 == 2);
        return ok && (int'(a[1:0]) % size_m(f3) == 0);
    endfunction

    function automatic logic [3:0] sel_m(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_m(f3);
        return (sz == 4) ? 4'hF : 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] wd_m(input logic [2:0] f3, input logic [31:0] sd);
        int sz = size_m(f3);
        return (sz == 1) ? sd[7:0] * 32'h01010101 : (sz == 2) ? sd[15:0] * 32'h00010001 : sd;
    endfunction

    function automatic logic [31:0] ld_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        int sz = size_m(f3);
        v = rd >> (8 * a[1:0]);
        if (sz == 1) begin
            v = v & 32'd255;
            if (f3 == 0 && v >= 128) v = v + 32'hFFFFFF00;
        end else if (sz == 2) begin
            v = v & 32'd65535;
            if (f3 == 1 && v >= 32768) v = v + 32'hFFFF0000;
        end
        return v;
    endfunction

    task automatic fill_ld(input int from, input logic [31:0] v);
        for (int c = from; c < N; c++) exp_ld[c] = v;
    endtask

    // one request; k = cycle of bus_ack relative to the request (0 = never), intr = poke ignored requests
    task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int k, input bit intr);
        int c0 = cyc;
        int last;
        int end_c;
        bit lg = legal_m(ld, f3, a);
        req_load = ld; req_store = st; funct3 = f3; addr = a; store_data = sd;
        if (!lg) begin
            exp_err[c0 + 1] = 1;
            end_c = c0 + 1;
        end else begin
            last = (k == 0) ? c0 + TO : c0 + k;
            end_c = (k == 0) ? last + 1 : last + 2;
            exp_stall[c0] = 1;
            for (int c = c0 + 1; c <= last; c++) begin
                exp_req[c] = 1; exp_stall[c] = 1; exp_we[c] = !ld;
                exp_addr[c] = a & ~32'd3; exp_sel[c] = sel_m(f3, a); exp_wd[c] = wd_m(f3, sd);
            end
            if (k == 0) exp_to[last + 1] = 1;
            else if (ld) begin
                exp_lv[last + 1] = 1;
                fill_ld(last + 1, ld_m(f3, a, rd));
            end
        end
        @(posedge clk); #1;
        while (cyc < end_c) begin
            req_load = 0; req_store = 0;
            if (intr && cyc == c0 + 1) begin
                req_store = 1; addr = 32'h0000_0F00; funct3 = 3'b010; store_data = 32'h11111111;
            end
            if (intr && k != 0 && cyc == c0 + k + 1) begin
                req_load = 1; addr = 32'h0000_0040; funct3 = 3'b010;
            end
            bus_ack = (k != 0 && cyc == c0 + k);
            bus_rdata = bus_ack ? rd : $urandom;
            @(posedge clk); #1;
        end
        req_load = 0; req_store = 0; bus_ack = 0;
    endtask

    // single compare process against the timeline
    always @(negedge clk) begin
        if (checks_on && cyc < N) begin
            chk("bus_req", bus_req, exp_req[cyc]);
            chk("stall", stall, exp_stall[cyc]);
            chk("load_valid", load_valid, exp_lv[cyc]);
            chk("access_err", access_err, exp_err[cyc]);
            chk("timeout_err", timeout_err, exp_to[cyc]);
            chk("load_data", load_data, exp_ld[cyc]);
            if (exp_req[cyc]) begin
                chk("bus_we", bus_we, exp_we[cyc]);
                chk("bus_addr", bus_addr, exp_addr[cyc]);
                chk("bus_sel", bus_sel, exp_sel[cyc]);
                if (exp_we[cyc]) chk("bus_wdata", bus_wdata, exp_wd[cyc]);
            end
            if (bus_req) begin
                snap_wd = bus_wdata; snap_sel = bus_sel; snap_we = bus_we;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        @(posedge clk); #1;
        checks_on = 1;
        chk("reset_load_data", load_data, 32'h0);
        chk("reset_bus_sel", {28'h0, bus_sel}, 32'h0);
        @(posedge clk); #1;
        rst = 0;
        txn(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0);
        chk("lw_literal", load_data, 32'hDEADBEEF);
        txn(1, 0, 3'b000, 32'h103, 0, 32'h80112233, 2, 0);
        chk("lb_literal", load_data, 32'hFFFFFF80);
        txn(1, 0, 3'b100, 32'h103, 0, 32'h80112233, 1, 0);
        chk("lbu_literal", load_data, 32'h00000080);
        txn(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h5A5A5A5A, 2, 0);
        chk("sh_wdata_literal", snap_wd, 32'hABCDABCD);
        chk("sh_sel_literal", {28'h0, snap_sel}, 32'hC);
        chk("sh_we_literal", {31'h0, snap_we}, 32'h1);
        chk("sh_keeps_load_data", load_data, 32'h00000080);
        txn(1, 0, 3'b010, 32'h101, 0, 0, 2, 0);
        txn(1, 0, 3'b010, 32'h400, 0, 32'h12345678, 0, 0);
        txn(1, 0, 3'b001, 32'h102, 0, 32'hBEEF1234, TO, 0);
        chk("lh_literal", load_data, 32'hFFFFBEEF);
        txn(1, 0, 3'b101, 32'h106, 0, 32'h80010000, 2, 1);
        chk("lhu_literal", load_data, 32'h00008001);
        txn(0, 1, 3'b000, 32'h205, 32'h000000A5, 0, 1, 0);
        txn(0, 1, 3'b010, 32'h208, 32'hCAFEF00D, 0, 3, 1);
        txn(1, 1, 3'b010, 32'h10C, 32'h99999999, 32'h0BADF00D, 2, 0);
        txn(0, 1, 3'b100, 32'h200, 32'h1, 0, 2, 0);
        txn(1, 0, 3'b011, 32'h200, 0, 0, 2, 0);
        txn(1, 0, 3'b110, 32'h200, 0, 0, 2, 0);
        txn(0, 1, 3'b001, 32'h201, 32'h1, 0, 2, 0);
        txn(1, 0, 3'b001, 32'h103, 0, 0, 2, 0);
        txn(1, 0, 3'b000, 32'h100, 0, 32'h0000007F, 1, 0);
        chk("lb_pos_literal", load_data, 32'h0000007F);
        bus_ack = 1; bus_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        bus_ack = 0;
        @(posedge clk); #1;
        c0 = cyc;
        req_load = 1; addr = 32'h300; funct3 = 3'b010;
        exp_stall[c0] = 1;
        exp_stall[c0 + 1] = 1;
        for (int c = c0 + 1; c <= c0 + 2; c++) begin
            exp_req[c] = 1; exp_addr[c] = 32'h300; exp_sel[c] = 4'hF; exp_we[c] = 0;
        end
        fill_ld(c0 + 3, 32'h0);
        @(posedge clk); #1;
        req_load = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; bus_ack = 1; bus_rdata = 32'h00000055;
        chk("rst_bus_addr", bus_addr, 32'h0);
        chk("rst_bus_sel", {28'h0, bus_sel}, 32'h0);
        chk("rst_bus_wdata", bus_wdata, 32'h0);
        chk("rst_bus_we", {31'h0, bus_we}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        @(posedge clk); #1;
        bus_ack = 0;
        @(posedge clk); #1;
        txn(1, 0, 3'b010, 32'h104, 0, 32'h76543210, 2, 0);
        chk("post_rst_literal", load_data, 32'h76543210);
        repeat (3) @(posedge clk);
        #1;
        checks_on = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
